// File: rtl/alu_flag_resolve.sv
// Resolves ALU flags into set-instruction results and branch decisions, then
// buffers them in a 2-entry skid buffer between EX and MEM.
module alu_flag_resolve #(
  parameter int N     = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     alu_out,
  input  logic             zero,
  input  logic             ofl,
  input  logic             carry,
  input  logic             neg,
  input  logic [3:0]       cond,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     res,
  output logic             take,
  output logic             illegal,
  output logic [CNT_W-1:0] ofl_cnt,
  input  logic             ofl_clr
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t         state;
  state_t         state_nxt;
  logic           push;
  logic           pop;
  logic           head_load_new;
  logic           head_load_sec;
  logic           sec_load;
  logic [N-1:0]   new_res;
  logic           new_take;
  logic           new_illegal;
  logic [N-1:0]   sec_res;
  logic           sec_take;
  logic           sec_illegal;

  // Handshake flags depend only on the occupancy register, never on out_ready.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    new_res     = alu_out;
    new_take    = 1'b0;
    new_illegal = 1'b0;
    case (cond)
      4'd0: new_res = alu_out;
      4'd1: new_res = {{(N-1){1'b0}}, zero};
      4'd2: new_res = {{(N-1){1'b0}}, neg ^ ofl};
      4'd3: new_res = {{(N-1){1'b0}}, (neg ^ ofl) | zero};
      4'd4: new_res = {{(N-1){1'b0}}, carry};
      4'd5: new_take = zero;
      4'd6: new_take = ~zero;
      4'd7: new_take = neg;
      4'd8: new_take = ~neg;
      default: new_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Push with a simultaneous pop in ONE replaces the head directly.
  always_comb begin
    state_nxt     = state;
    head_load_new = 1'b0;
    head_load_sec = 1'b0;
    sec_load      = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          state_nxt     = ONE;
          head_load_new = 1'b1;
        end
      end
      ONE: begin
        case ({push, pop})
          2'b10: begin
            state_nxt = TWO;
            sec_load  = 1'b1;
          end
          2'b01: state_nxt = EMPTY;
          2'b11: head_load_new = 1'b1;
          default: state_nxt = ONE;
        endcase
      end
      TWO: begin
        if (pop) begin
          state_nxt     = ONE;
          head_load_sec = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res         <= '0;
      take        <= 1'b0;
      illegal     <= 1'b0;
      sec_res     <= '0;
      sec_take    <= 1'b0;
      sec_illegal <= 1'b0;
    end else begin
      if (head_load_new) begin
        res     <= new_res;
        take    <= new_take;
        illegal <= new_illegal;
      end else if (head_load_sec) begin
        res     <= sec_res;
        take    <= sec_take;
        illegal <= sec_illegal;
      end
      if (sec_load) begin
        sec_res     <= new_res;
        sec_take    <= new_take;
        sec_illegal <= new_illegal;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || ofl_clr)
      ofl_cnt <= '0;
    else if (push && (cond == 4'd0) && ofl && (ofl_cnt != CNT_MAX))
      ofl_cnt <= ofl_cnt + 1'b1;
  end

endmodule

// File: tb/tb_alu_flag_resolve.sv
// Directed-vector bench for alu_flag_resolve with hand-computed expectations.
module tb_alu_flag_resolve;

  localparam int N     = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     alu_out;
  logic             zero;
  logic             ofl;
  logic             carry;
  logic             neg;
  logic [3:0]       cond;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     res;
  logic             take;
  logic             illegal;
  logic [CNT_W-1:0] ofl_cnt;
  logic             ofl_clr;

  int compare_count  = 0;
  int mismatch_count = 0;

  alu_flag_resolve #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .zero(zero), .ofl(ofl), .carry(carry), .neg(neg),
    .cond(cond), .out_valid(out_valid), .out_ready(out_ready), .res(res),
    .take(take), .illegal(illegal), .ofl_cnt(ofl_cnt), .ofl_clr(ofl_clr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] c, input logic [N-1:0] a,
                               input logic z, input logic o, input logic cy, input logic n);
    in_valid = v;
    cond     = c;
    alu_out  = a;
    zero     = z;
    ofl      = o;
    carry    = cy;
    neg      = n;
  endtask

  // Streams one entry with out_ready high and checks the resolved head next cycle.
  task automatic pushCheck(input string tag, input logic [3:0] c, input logic [N-1:0] a,
                           input logic z, input logic o, input logic cy, input logic n,
                           input logic [N-1:0] exp_res, input logic exp_take,
                           input logic exp_ill);
    applyStimulus(1'b1, c, a, z, o, cy, n);
    out_ready = 1'b1;
    step();
    checkOutput({tag, ".valid"},   {31'd0, out_valid}, 32'd1);
    checkOutput({tag, ".res"},     {16'd0, res},       {16'd0, exp_res});
    checkOutput({tag, ".take"},    {31'd0, take},      {31'd0, exp_take});
    checkOutput({tag, ".illegal"}, {31'd0, illegal},   {31'd0, exp_ill});
  endtask

  task automatic drain();
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
  endtask

  initial begin
    rst       = 1'b1;
    ofl_clr   = 1'b0;
    out_ready = 1'b0;
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    checkOutput("rst.out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst.in_ready",  {31'd0, in_ready},  32'd1);
    checkOutput("rst.res",       {16'd0, res},       32'd0);
    checkOutput("rst.take",      {31'd0, take},      32'd0);
    checkOutput("rst.illegal",   {31'd0, illegal},   32'd0);
    checkOutput("rst.ofl_cnt",   {24'd0, ofl_cnt},   32'd0);
    rst = 1'b0;

    // Set instructions
    pushCheck("seq1",  4'd1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0);
    pushCheck("seq0",  4'd1, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    pushCheck("slt1",  4'd2, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0);
    pushCheck("slt0",  4'd2, 16'h8001, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    pushCheck("sle1",  4'd3, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0);
    pushCheck("sle0",  4'd3, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    pushCheck("sco1",  4'd4, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
    pushCheck("pass",  4'd0, 16'h5A5A, 1'b0, 1'b0, 1'b1, 1'b0, 16'h5A5A, 1'b0, 1'b0);

    // Branches and reserved condition codes
    pushCheck("beqz",  4'd5, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b0);
    pushCheck("bnez",  4'd6, 16'h0042, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0042, 1'b1, 1'b0);
    pushCheck("bltz",  4'd7, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0);
    pushCheck("bgez",  4'd8, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    pushCheck("rsv12", 4'd12, 16'hABCD, 1'b1, 1'b1, 1'b1, 1'b1, 16'hABCD, 1'b0, 1'b1);
    pushCheck("rsv15", 4'd15, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0F0F, 1'b0, 1'b1);
    checkOutput("cnt.still0", {24'd0, ofl_cnt}, 32'd0);
    drain();
    checkOutput("drain.valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: A and B fill the buffer, C is held off until space frees up
    out_ready = 1'b0;
    applyStimulus(1'b1, 4'd0, 16'hA001, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("bp.A.in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("bp.A.res",      {16'd0, res},      32'h0000A001);
    applyStimulus(1'b1, 4'd0, 16'hB002, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("bp.B.in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("bp.B.head",     {16'd0, res},      32'h0000A001);
    applyStimulus(1'b1, 4'd0, 16'hC003, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("bp.C.in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("bp.C.head",     {16'd0, res},      32'h0000A001);
    out_ready = 1'b1;
    step();
    checkOutput("bp.out2.res",   {16'd0, res},       32'h0000B002);
    checkOutput("bp.out2.valid", {31'd0, out_valid}, 32'd1);
    checkOutput("bp.out2.ready", {31'd0, in_ready},  32'd1);
    step();
    checkOutput("bp.out3.res",   {16'd0, res},       32'h0000C003);
    checkOutput("bp.out3.valid", {31'd0, out_valid}, 32'd1);
    drain();
    checkOutput("bp.empty", {31'd0, out_valid}, 32'd0);

    // Streaming push and pop every cycle
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 4'd0, 16'(i + 16'h0100), 1'b0, 1'b0, 1'b0, 1'b0);
      out_ready = 1'b1;
      step();
      checkOutput($sformatf("stream%0d.res", i), {16'd0, res}, 32'(i + 32'h100));
      checkOutput($sformatf("stream%0d.rdy", i), {31'd0, in_ready}, 32'd1);
    end
    drain();

    // Overflow event counter saturation and clear priority
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 4'd0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
      out_ready = 1'b1;
      step();
      if (i == 99) checkOutput("cnt.100", {24'd0, ofl_cnt}, 32'd100);
    end
    checkOutput("cnt.sat", {24'd0, ofl_cnt}, 32'd255);
    ofl_clr = 1'b1;
    step();
    checkOutput("cnt.clr", {24'd0, ofl_cnt}, 32'd0);
    ofl_clr = 1'b0;
    step();
    checkOutput("cnt.after_clr", {24'd0, ofl_cnt}, 32'd1);
    applyStimulus(1'b1, 4'd2, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("cnt.non_pass", {24'd0, ofl_cnt}, 32'd1);

    // Reset with both entries occupied
    out_ready = 1'b0;
    applyStimulus(1'b1, 4'd0, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("full.in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    checkOutput("rst2.out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst2.in_ready",  {31'd0, in_ready},  32'd1);
    checkOutput("rst2.ofl_cnt",   {24'd0, ofl_cnt},   32'd0);
    checkOutput("rst2.res",       {16'd0, res},       32'd0);
    step();
    checkOutput("rst2.stay_empty", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
